// File: rtl/adder_pkg.sv
// Shared constants and FSM state encoding for the wide add/subtract sequencer.
package adder_pkg;

   localparam int unsigned DEF_SLICE_W = 16;
   localparam int unsigned DEF_WORDS   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/adder_slice16.sv
// SLICE_W-bit ripple-carry adder shared across all beats of a wide operation.
module adder_slice16
   import adder_pkg::*;
#(
   parameter int unsigned SLICE_W = DEF_SLICE_W
) (
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               c_in,
   output logic [SLICE_W-1:0] s,
   output logic               c_out
);

   logic [SLICE_W:0] c;

   assign c[0] = c_in;

   for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
      full_adder u_fa (
         .a     (a[i]),
         .b     (b[i]),
         .c_in  (c[i]),
         .s     (s[i]),
         .c_out (c[i+1])
      );
   end

   assign c_out = c[SLICE_W];

endmodule

// File: rtl/full_adder.sv
// Single-bit full-adder cell used to build the ripple slice.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic c_out
);

   assign s     = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide add/subtract performed LSB-slice first over WORDS beats through one
// shared ripple slice, with the carry held in a register between beats.
module wide_add_sequencer
   import adder_pkg::*;
#(
   parameter  int unsigned SLICE_W = DEF_SLICE_W,
   parameter  int unsigned WORDS   = DEF_WORDS,
   localparam int unsigned W       = SLICE_W * WORDS,
   localparam int unsigned BW      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result,
   output logic         carry_out,
   output logic         overflow,
   output logic         busy
);

   state_e                       state_q;
   logic [BW-1:0]                beat_q;
   logic                         carry_q;
   logic [WORDS-1:0][SLICE_W-1:0] a_q;
   logic [WORDS-1:0][SLICE_W-1:0] b_q;
   logic [WORDS-1:0][SLICE_W-1:0] res_q;
   logic                         carry_out_q;
   logic                         overflow_q;
   logic                         out_valid_q;

   logic [SLICE_W-1:0]           slice_sum_d;
   logic                         slice_cout_d;
   logic                         last_beat;
   logic                         a_msb;
   logic                         b_msb;

   adder_slice16 #(
      .SLICE_W (SLICE_W)
   ) u_slice (
      .a     (a_q[beat_q]),
      .b     (b_q[beat_q]),
      .c_in  (carry_q),
      .s     (slice_sum_d),
      .c_out (slice_cout_d)
   );

   assign last_beat = (beat_q == BW'(WORDS - 1));
   assign a_msb     = a_q[WORDS-1][SLICE_W-1];
   assign b_msb     = b_q[WORDS-1][SLICE_W-1];

   // Subtraction is a + ~b + 1: the inverted operand is stored and the +1
   // enters as the initial carry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= op_a;
                  b_q     <= sub ? ~op_b : op_b;
                  carry_q <= sub;
                  beat_q  <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               res_q[beat_q] <= slice_sum_d;
               carry_q       <= slice_cout_d;
               if (last_beat) begin
                  carry_out_q <= slice_cout_d;
                  overflow_q  <= (a_msb == b_msb) && (slice_sum_d[SLICE_W-1] != a_msb);
                  out_valid_q <= 1'b1;
                  beat_q      <= '0;
                  state_q     <= DONE;
               end else begin
                  beat_q <= beat_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign result    = res_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: directed corner cases plus random add/sub
// against a plain 65-bit arithmetic reference.
module tb_wide_add_sequencer;

   localparam int unsigned W = 64;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;
   logic         busy;

   int total = 0;
   int bad   = 0;

   wide_add_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference: {overflow, carry_out, result} from plain wide arithmetic.
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
      logic [W:0]   t;
      logic [W-1:0] r;
      logic         ov;
      if (s) t = {1'b0, a} + {1'b0, ~b} + 65'd1;
      else   t = {1'b0, a} + {1'b0, b};
      r = t[W-1:0];
      if (s) ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      else   ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      return {ov, t[W], r};
   endfunction

   // Issues one operation from IDLE, waits (bounded) for out_valid, drains it.
   // Starts and ends 1 time unit after a rising edge.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] r, output logic co, output logic ov,
                         output int lat);
      in_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      sub      = s;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      r  = result;
      co = carry_out;
      ov = overflow;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ctrl: out_valid=%b busy=%b in_ready=%b, want 0 0 1",
                  out_valid, busy, in_ready);
      end
      total++;
      if (result !== 64'd0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL reset_data: result=%h co=%b ov=%b, want 0 0 0",
                  result, carry_out, overflow);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] a_v[6];
      logic [W-1:0] b_v[6];
      logic         s_v[6];
      logic [W-1:0] r_exp[6];
      logic         co_exp[6];
      logic         ov_exp[6];
      logic [W-1:0] r;
      logic         co, ov;
      int           lat;
      a_v = '{64'h0000_0000_0000_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
              64'd5, 64'h8000_0000_0000_0000, 64'hFFFF_0000_FFFF_0000};
      b_v = '{64'd1, 64'd1, 64'd1, 64'd7, 64'd1, 64'h0001_0000_0001_0000};
      s_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      r_exp  = '{64'h0000_0000_0001_0000, 64'd0, 64'h8000_0000_0000_0000,
                 64'hFFFF_FFFF_FFFF_FFFE, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000};
      co_exp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      ov_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         run_op(a_v[i], b_v[i], s_v[i], r, co, ov, lat);
         total++;
         if (lat != 4) begin
            bad++;
            $display("FAIL dir%0d_latency: got %0d cycles, want 4", i, lat);
         end
         total++;
         if (r !== r_exp[i] || co !== co_exp[i] || ov !== ov_exp[i]) begin
            bad++;
            $display("FAIL dir%0d_result: got %h co=%b ov=%b, want %h co=%b ov=%b",
                     i, r, co, ov, r_exp[i], co_exp[i], ov_exp[i]);
         end
         total++;
         if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL dir%0d_drain: in_ready=%b busy=%b, want 1 0", i, in_ready, busy);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W+1:0] exp1, exp2;
      logic [W-1:0] r_hold;
      logic         co_hold, ov_hold;
      int           lat;
      int           errs;
      exp1 = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
      exp2 = model(64'h0000_0000_0000_0064, 64'h0000_0000_0000_00C8, 1'b1);
      in_valid = 1'b1;
      op_a     = 64'h1234_5678_9ABC_DEF0;
      op_b     = 64'h0FED_CBA9_8765_4321;
      sub      = 1'b0;
      @(posedge clk); #1;
      op_a = 64'h0000_0000_0000_0064;
      op_b = 64'h0000_0000_0000_00C8;
      sub  = 1'b1;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      total++;
      if (lat != 4 || result !== exp1[W-1:0] || carry_out !== exp1[W] || overflow !== exp1[W+1]) begin
         bad++;
         $display("FAIL bp_first: lat=%0d result=%h co=%b ov=%b, want lat=4 %h co=%b ov=%b",
                  lat, result, carry_out, overflow, exp1[W-1:0], exp1[W], exp1[W+1]);
      end
      r_hold  = result;
      co_hold = carry_out;
      ov_hold = overflow;
      errs = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (result !== r_hold || carry_out !== co_hold || overflow !== ov_hold ||
             out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
            errs++;
      end
      total++;
      if (errs != 0 || result !== exp1[W-1:0]) begin
         bad++;
         $display("FAIL bp_hold: %0d unstable cycles, result=%h out_valid=%b in_ready=%b, want 0 %h 1 0",
                  errs, result, out_valid, in_ready, exp1[W-1:0]);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL bp_to_idle: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                  in_ready, out_valid, busy);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      total++;
      if (lat != 4 || result !== exp2[W-1:0] || carry_out !== exp2[W] || overflow !== exp2[W+1]) begin
         bad++;
         $display("FAIL bp_second: lat=%0d result=%h co=%b ov=%b, want lat=4 %h co=%b ov=%b",
                  lat, result, carry_out, overflow, exp2[W-1:0], exp2[W], exp2[W+1]);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      logic [W-1:0] r;
      logic         co, ov;
      int           lat;
      in_valid = 1'b1;
      op_a     = 64'h1111_2222_3333_4444;
      op_b     = 64'd1;
      sub      = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      total++;
      if (busy !== 1'b1 || out_valid !== 1'b0 || result[47:0] !== 48'h2222_3333_4445) begin
         bad++;
         $display("FAIL mid_run_partial: busy=%b out_valid=%b low48=%h, want 1 0 222233334445",
                  busy, out_valid, result[47:0]);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 64'd0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL async_reset: out_valid=%b busy=%b result=%h in_ready=%b, want 0 0 0 1",
                  out_valid, busy, result, in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      run_op(64'd1, 64'd2, 1'b0, r, co, ov, lat);
      total++;
      if (lat != 4 || r !== 64'd3 || co !== 1'b0 || ov !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_op: lat=%0d result=%h co=%b ov=%b, want 4 3 0 0",
                  lat, r, co, ov);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b;
      logic         s;
      logic [W+1:0] exp;
      logic [W-1:0] r;
      logic         co, ov;
      int           lat;
      for (int n = 0; n < 40; n++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if (n % 8 == 3) b = ~a;
         if (n % 8 == 5) b = a;
         s = 1'($urandom_range(0, 1));
         exp = model(a, b, s);
         run_op(a, b, s, r, co, ov, lat);
         total++;
         if (lat != 4 || r !== exp[W-1:0] || co !== exp[W] || ov !== exp[W+1]) begin
            bad++;
            $display("FAIL rand%0d: a=%h b=%h sub=%b lat=%0d got %h co=%b ov=%b, want %h co=%b ov=%b",
                     n, a, b, s, lat, r, co, ov, exp[W-1:0], exp[W], exp[W+1]);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      sub       = 1'b0;
      out_ready = 1'b0;
      #3;
      test_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
